// File: rtl/mod_counter_if.sv
// -----------------------------------------------------------------------------
// mod_counter_if -- control/status bundle for mod_counter.
//
// Parameters
//   N   count width in bits (2..32)
//   PW  prescaler width in bits (only meaningful with MOD_COUNTER_PRESCALE_EN)
//
// Signals
//   funct     [2:0]   operation: 0 CLEAR, 1 HOLD, 2 UP, 3 DOWN, 4 LOAD, 5-7 HOLD
//   mode      [1:0]   terminal behaviour: 0 WRAP, 1 SATURATE, 2 ONESHOT, 3 WRAP
//   din       [N-1:0] load value
//   limit     [N-1:0] upper terminal value
//   prescale  [PW-1:0] tick divisor minus one (MOD_COUNTER_PRESCALE_EN only)
//   dout      [N-1:0] registered count
//   at_limit          combinational, dout >= limit
//   tc                registered one-cycle terminal-count pulse
//   done              registered, ONESHOT completed
//
// Modports
//   master  drives the controls, observes the status (testbench / host)
//   slave   the counter itself
//
// Optional feature macro: MOD_COUNTER_PRESCALE_EN adds the prescale signal.
// -----------------------------------------------------------------------------
interface mod_counter_if #(
  parameter int N  = 8,
  parameter int PW = 4
);

  logic [2:0]    funct;
  logic [1:0]    mode;
  logic [N-1:0]  din;
  logic [N-1:0]  limit;
`ifdef MOD_COUNTER_PRESCALE_EN
  logic [PW-1:0] prescale;
`endif
  logic [N-1:0]  dout;
  logic          at_limit;
  logic          tc;
  logic          done;

  // Reject unsupported widths at elaboration time.
  if (N < 2 || N > 32 || PW < 1 || PW > 32) begin : g_bad_params
    $error("mod_counter_if: N must be 2..32 and PW 1..32");
  end

  modport master (
`ifdef MOD_COUNTER_PRESCALE_EN
    output prescale,
`endif
    output funct,
    output mode,
    output din,
    output limit,
    input  dout,
    input  at_limit,
    input  tc,
    input  done
  );

  modport slave (
`ifdef MOD_COUNTER_PRESCALE_EN
    input  prescale,
`endif
    input  funct,
    input  mode,
    input  din,
    input  limit,
    output dout,
    output at_limit,
    output tc,
    output done
  );

endinterface

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter -- programmable up/down counter with WRAP / SATURATE / ONESHOT
// terminal behaviour, synchronous CLEAR/LOAD/HOLD and an optional prescaler.
//
// Parameters
//   N   count width in bits (2..32)
//   PW  prescaler width in bits (used only with MOD_COUNTER_PRESCALE_EN)
//
// Ports
//   clk      rising-edge clock for all state
//   reset_n  asynchronous active-low reset (clears count, tc, done, sat and
//            prescaler)
//   bus      mod_counter_if.slave: funct, mode, din, limit, [prescale] in;
//            dout, at_limit, tc, done out
//
// Optional feature macro: MOD_COUNTER_PRESCALE_EN
//   defined   : a PW-bit prescaler counts cycles on which an UP/DOWN request is
//               pending and done = 0; a step is only taken on the cycle the
//               prescaler equals bus.prescale, after which it restarts at 0.
//   undefined : no prescaler, every UP/DOWN request cycle is a step.
//
// Terminal conditions: up-terminal is dout >= limit, down-terminal is dout == 0.
// A terminal step in WRAP/ONESHOT reloads the opposite end (0 or limit) and
// pulses tc; ONESHOT also sets done, which blocks further steps until CLEAR or
// LOAD. SATURATE keeps dout and pulses tc only on the first terminal step; the
// sat flag suppresses repeats until dout moves again or is cleared/loaded.
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int N  = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  mod_counter_if.slave  bus
);

  // Operation codes
  localparam logic [2:0] F_CLEAR = 3'd0;
  localparam logic [2:0] F_UP    = 3'd2;
  localparam logic [2:0] F_DOWN  = 3'd3;
  localparam logic [2:0] F_LOAD  = 3'd4;

  // Terminal behaviour codes (code 3 is folded onto WRAP)
  localparam logic [1:0] M_WRAP    = 2'd0;
  localparam logic [1:0] M_SAT     = 2'd1;
  localparam logic [1:0] M_ONESHOT = 2'd2;
  localparam logic [1:0] M_ALIAS   = 2'd3;

  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE  = N'(1);

  // Reject unsupported widths at elaboration time.
  if (N < 2 || N > 32 || PW < 1 || PW > 32) begin : g_bad_params
    $error("mod_counter: N must be 2..32 and PW 1..32");
  end

  logic [N-1:0] cnt;
  logic [N-1:0] cnt_nxt;
  logic         tc_q;
  logic         tc_nxt;
  logic         done_q;
  logic         done_nxt;
  logic         sat_q;
  logic         sat_nxt;

  logic         is_dir;
  logic         is_up;
  logic         tick;
  logic         step;
  logic         term;
  logic [1:0]   mode_eff;

  // ---------------------------------------------------------------------------
  // Step qualification
  // ---------------------------------------------------------------------------
  assign is_dir = (bus.funct == F_UP) || (bus.funct == F_DOWN);
  assign is_up  = (bus.funct == F_UP);

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_nxt;

  assign tick = (pre_q == bus.prescale);

  // Prescaler next value: restarts on CLEAR/LOAD/tick, advances only while a
  // step is being requested and the counter is not blocked, frozen otherwise.
  always_comb begin
    pre_nxt = pre_q;
    case (bus.funct)
      F_CLEAR, F_LOAD: begin
        pre_nxt = PRE_ZERO;
      end
      F_UP, F_DOWN: begin
        if (done_q) begin
          pre_nxt = pre_q;
        end else if (tick) begin
          pre_nxt = PRE_ZERO;
        end else begin
          pre_nxt = pre_q + PRE_ONE;
        end
      end
      default: begin
        pre_nxt = pre_q;
      end
    endcase
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= PRE_ZERO;
    end else begin
      pre_q <= pre_nxt;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign step     = is_dir && tick && !done_q;
  assign mode_eff = (bus.mode == M_ALIAS) ? M_WRAP : bus.mode;

  // Terminal test uses the current count and the current limit, so a limit
  // change only influences steps that have not yet been taken.
  assign term = is_up ? (cnt >= bus.limit) : (cnt == CNT_ZERO);

  // ---------------------------------------------------------------------------
  // Next-state logic for count, tc, done and sat
  // ---------------------------------------------------------------------------
  // Decode funct/mode into the next count and flag values.
  always_comb begin
    cnt_nxt  = cnt;
    tc_nxt   = 1'b0;
    done_nxt = done_q;
    sat_nxt  = sat_q;
    case (bus.funct)
      F_CLEAR: begin
        cnt_nxt  = CNT_ZERO;
        done_nxt = 1'b0;
        sat_nxt  = 1'b0;
      end
      F_LOAD: begin
        cnt_nxt  = bus.din;
        done_nxt = 1'b0;
        sat_nxt  = 1'b0;
      end
      F_UP, F_DOWN: begin
        if (!step) begin
          cnt_nxt = cnt;
        end else if (!term) begin
          // Ordinary move; dout leaves any terminal so sat is released.
          cnt_nxt = is_up ? (cnt + CNT_ONE) : (cnt - CNT_ONE);
          sat_nxt = 1'b0;
        end else begin
          case (mode_eff)
            M_SAT: begin
              cnt_nxt = cnt;
              tc_nxt  = !sat_q;
              sat_nxt = 1'b1;
            end
            M_ONESHOT: begin
              cnt_nxt  = is_up ? CNT_ZERO : bus.limit;
              tc_nxt   = 1'b1;
              done_nxt = 1'b1;
            end
            default: begin
              cnt_nxt = is_up ? CNT_ZERO : bus.limit;
              tc_nxt  = 1'b1;
            end
          endcase
        end
      end
      default: begin
        // HOLD and reserved codes: everything frozen, tc drops.
        cnt_nxt = cnt;
      end
    endcase
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= CNT_ZERO;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      tc_q   <= tc_nxt;
      done_q <= done_nxt;
      sat_q  <= sat_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.dout     = cnt;
  assign bus.tc       = tc_q;
  assign bus.done     = done_q;
  assign bus.at_limit = (cnt >= bus.limit);

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter -- directed self-checking bench for mod_counter.
// A behavioural model (integer arithmetic on the counter rules) is checked
// against the DUT on every falling edge; literal expectations for the
// documented scenarios pin the model itself.
// -----------------------------------------------------------------------------
module tb_mod_counter;

  localparam int N  = 8;
  localparam int PW = 4;

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  mod_counter_if #(.N(N), .PW(PW)) bus ();

  mod_counter #(.N(N), .PW(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;
  int ps_val   = 0;

  typedef struct {
    int dout;
    bit tc;
    bit done;
    bit sat;
    int pre;
  } mst_t;

  mst_t m = '{dout: 0, tc: 1'b0, done: 1'b0, sat: 1'b0, pre: 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Counter rules applied to a whole-number state.
  function automatic mst_t model_next(mst_t s, int f, int md, int d, int l, int ps);
    mst_t r;
    bit   tk;
    bit   up;
    bit   at_term;
    int   mm;
    r    = s;
    r.tc = 1'b0;
    if (f == 0) begin
      r.dout = 0; r.done = 1'b0; r.sat = 1'b0; r.pre = 0;
    end else if (f == 4) begin
      r.dout = d; r.done = 1'b0; r.sat = 1'b0; r.pre = 0;
    end else if ((f == 2 || f == 3) && !s.done) begin
      tk    = !PRE_EN || (s.pre == ps);
      r.pre = tk ? 0 : (s.pre + 1) % (1 << PW);
      if (tk) begin
        up      = (f == 2);
        at_term = up ? (s.dout >= l) : (s.dout == 0);
        mm      = (md == 3) ? 0 : md;
        if (!at_term) begin
          r.dout = up ? (s.dout + 1) % (1 << N) : s.dout - 1;
          r.sat  = 1'b0;
        end else if (mm == 1) begin
          r.tc  = !s.sat;
          r.sat = 1'b1;
        end else begin
          r.dout = up ? 0 : l;
          r.tc   = 1'b1;
          if (mm == 2) r.done = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Model state update, mirroring the asynchronous reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m <= '{dout: 0, tc: 1'b0, done: 1'b0, sat: 1'b0, pre: 0};
    end else begin
      m <= model_next(m, int'(bus.funct), int'(bus.mode), int'(bus.din),
                      int'(bus.limit), ps_val);
    end
  end

  // Per-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_dout",     int'(bus.dout),     m.dout);
      chk("model_tc",       int'(bus.tc),       int'(m.tc));
      chk("model_done",     int'(bus.done),     int'(m.done));
      chk("model_at_limit", int'(bus.at_limit), (m.dout >= int'(bus.limit)) ? 1 : 0);
    end
  end

  // One clock cycle with the given controls; returns on the next falling edge.
  task automatic cyc(input int f, input int md, input int d, input int l);
    #1;
    bus.funct = f[2:0];
    bus.mode  = md[1:0];
    bus.din   = d[N-1:0];
    bus.limit = l[N-1:0];
`ifdef MOD_COUNTER_PRESCALE_EN
    bus.prescale = ps_val[PW-1:0];
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  int exp_a [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
  int exp_b [5] = '{1, 0, 0, 0, 0};
  int exp_c [5] = '{1, 2, 0, 0, 0};
  int exp_h [9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};

  initial begin
    bus.funct = 3'd1;
    bus.mode  = 2'd0;
    bus.din   = '0;
    bus.limit = '0;
`ifdef MOD_COUNTER_PRESCALE_EN
    bus.prescale = '0;
`endif

    // Reset state before any clock edge
    #3;
    chk("lit_rst_dout", int'(bus.dout), 0);
    chk("lit_rst_tc",   int'(bus.tc),   0);
    chk("lit_rst_done", int'(bus.done), 0);

    @(negedge clk);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // WRAP, limit 5, UP from reset
    for (int i = 0; i < 8; i++) begin
      cyc(2, 0, 0, 5);
      chk("lit_wrap_dout", int'(bus.dout), exp_a[i]);
      chk("lit_wrap_tc",   int'(bus.tc),   (i == 5) ? 1 : 0);
    end

    // SATURATE, limit 3, DOWN from 2
    cyc(4, 1, 2, 3);
    chk("lit_sat_load", int'(bus.dout), 2);
    for (int i = 0; i < 5; i++) begin
      cyc(3, 1, 0, 3);
      chk("lit_sat_dout", int'(bus.dout), exp_b[i]);
      chk("lit_sat_tc",   int'(bus.tc),   (i == 2) ? 1 : 0);
    end
    cyc(2, 1, 0, 3);
    chk("lit_sat_up", int'(bus.dout), 1);
    cyc(3, 1, 0, 3);
    chk("lit_sat_dn_tc0", int'(bus.tc), 0);
    cyc(3, 1, 0, 3);
    chk("lit_sat_retc", int'(bus.tc), 1);

    // ONESHOT, limit 2
    cyc(0, 2, 0, 2);
    for (int i = 0; i < 5; i++) begin
      cyc(2, 2, 0, 2);
      chk("lit_os_dout", int'(bus.dout), exp_c[i]);
      chk("lit_os_done", int'(bus.done), (i >= 2) ? 1 : 0);
      chk("lit_os_tc",   int'(bus.tc),   (i == 2) ? 1 : 0);
    end
    cyc(4, 2, 1, 2);
    chk("lit_os_load_done", int'(bus.done), 0);
    chk("lit_os_load_dout", int'(bus.dout), 1);

    // LOAD above limit, then UP wraps
    cyc(4, 0, 200, 10);
    chk("lit_big_dout",     int'(bus.dout),     200);
    chk("lit_big_at_limit", int'(bus.at_limit), 1);
    cyc(2, 0, 0, 10);
    chk("lit_big_wrap", int'(bus.dout), 0);
    chk("lit_big_tc",   int'(bus.tc),   1);

    // limit 0: every UP is terminal
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(2, 0, 0, 0);
      chk("lit_l0_dout", int'(bus.dout), 0);
      chk("lit_l0_tc",   int'(bus.tc),   1);
    end

    // mode 3 as WRAP, DOWN at 0 reloads limit; reserved funct holds
    cyc(3, 3, 0, 7);
    chk("lit_dnwrap_dout", int'(bus.dout), 7);
    chk("lit_dnwrap_tc",   int'(bus.tc),   1);
    cyc(6, 3, 0, 7);
    chk("lit_hold6_dout", int'(bus.dout), 7);
    chk("lit_hold6_tc",   int'(bus.tc),   0);

    // SATURATE at up-terminal, then raise limit
    cyc(4, 1, 9, 9);
    cyc(2, 1, 0, 9);
    chk("lit_satup_tc", int'(bus.tc), 1);
    cyc(2, 1, 0, 9);
    chk("lit_satup_rep", int'(bus.tc), 0);
    chk("lit_satup_dout", int'(bus.dout), 9);
    cyc(2, 1, 0, 20);
    chk("lit_newlimit", int'(bus.dout), 10);

    // Asynchronous reset mid-count
    cyc(0, 0, 0, 10);
    for (int i = 0; i < 4; i++) cyc(2, 0, 0, 10);
    chk("lit_pre_rst", int'(bus.dout), 4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("lit_arst_dout", int'(bus.dout), 0);
    chk("lit_arst_tc",   int'(bus.tc),   0);
    chk("lit_arst_done", int'(bus.done), 0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef MOD_COUNTER_PRESCALE_EN
    // Prescale 2: one step per three UP cycles, HOLD freezes the phase
    ps_val = 2;
    for (int i = 0; i < 9; i++) begin
      cyc(2, 0, 0, 9);
      chk("lit_ps_dout", int'(bus.dout), exp_h[i]);
    end
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 9);
    chk("lit_ps_hold", int'(bus.dout), 3);
    cyc(2, 0, 0, 9);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 9);
    cyc(2, 0, 0, 9);
    chk("lit_ps_phase", int'(bus.dout), 3);
    cyc(2, 0, 0, 9);
    chk("lit_ps_tick", int'(bus.dout), 4);
`else
    // Without prescaler every UP cycle steps immediately after reset
    cyc(2, 0, 0, 9);
    chk("lit_post_rst", int'(bus.dout), 1);
`endif

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
